mbus_ice_sl_drain: RTL and testbench

Slave-output-bus reader for the MBus ICE layer: the consumer end of the `sl_*` interface that `mbus_layer_wrapper_ice` exposes. It arbitrates between the wrapper's response producers (`sl_arb_request`) and walks the wrapper's 9-bit-wide response ring via `sl_addr`/`sl_data` until the end-of-frame marker. It forwards every word as a byte stream with valid/ready handshake to the host-side framer (UART/USB), then pulses `sl_latch_tail` to release the consumed ring space.

---
 rtl/mbus_ice_sl_drain.sv | 156 +++++++++++++++
 tb/tb_mbus_ice_sl_drain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_ice_sl_drain.sv
`default_nettype none
// ============================================================================
// Module   : mbus_ice_sl_drain
// Desc     : Arbitrates ICE slave-ring producers and drains one frame at a
//            time from the response ring into a host byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module mbus_ice_sl_drain #(
  parameter int  NUM_REQ = 2,
  parameter int  ADDR_W  = 9,
  parameter int  MAX_LEN = 256,
  localparam int c_src_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  output logic [ADDR_W-1:0]  sl_addr,
  input  logic [8:0]         sl_data,
  output logic               sl_latch_tail,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               out_err,
  output logic [c_src_w-1:0] out_src
);

  localparam int c_cnt_w = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAP   = 3'd2,
    S_SEND  = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  w_grant;
  logic [c_src_w-1:0]  r_src;
  logic [c_src_w-1:0]  r_rr_start;
  logic [c_src_w-1:0]  w_win;
  logic [c_src_w-1:0]  w_idx;
  logic [c_src_w-1:0]  w_src_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_hold;
  logic                r_last;
  logic                r_err;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic                w_any;
  logic                w_cnt_max;
  logic                w_fire;
  int                  w_sum;

  // Round-robin search beginning at the requester after the last one served.
  always_comb begin
    w_win   = '0;
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_rr_start) + k;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_idx = c_src_w'(w_sum);
      if (!w_any && sl_arb_request[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    w_grant[w_win] = 1'b1;
  end

  assign w_src_next = (int'(r_src) == NUM_REQ - 1) ? '0 : r_src + 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_max  = (w_cnt_inc == c_cnt_w'(MAX_LEN));
  assign w_fire     = (r_state == S_SEND) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_SEND;
      S_SEND:  if (out_ready) w_state_nxt = r_last ? S_LATCH : S_FETCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The ring pointer is persistent ring state: only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant    <= '0;
      r_src      <= '0;
      r_rr_start <= '0;
      r_addr     <= '0;
      r_hold     <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_grant;
            r_src   <= w_win;
            r_cnt   <= '0;
          end
        end
        S_CAP: begin
          r_hold <= sl_data[7:0];
          r_cnt  <= w_cnt_inc;
          r_last <= sl_data[8] | w_cnt_max;
          r_err  <= ~sl_data[8] & w_cnt_max;
        end
        S_SEND: begin
          if (w_fire) begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_LATCH: begin
          r_grant    <= '0;
          r_src      <= '0;
          r_rr_start <= w_src_next;
        end
        default: ;
      endcase
    end
  end

  assign sl_arb_grant  = r_grant;
  assign sl_addr       = r_addr;
  assign sl_latch_tail = (r_state == S_LATCH);
  assign out_valid     = (r_state == S_SEND);
  assign out_data      = r_hold;
  assign out_last      = out_valid & r_last;
  assign out_err       = out_valid & r_err;
  assign out_src       = r_src;

endmodule
`default_nettype wire

// File: tb/tb_mbus_ice_sl_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbus_ice_sl_drain
// Desc     : Self-checking bench for mbus_ice_sl_drain with a ring model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbus_ice_sl_drain;

  localparam int RING = 512;
  localparam int MAXL = 256;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       src;
    logic [8:0] addr;
  } beat_t;

  typedef struct {
    logic [1:0] req;
    int         exp_src;
  } arb_vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sl_arb_request = 2'b00;
  logic [1:0] sl_arb_grant;
  logic [8:0] sl_addr;
  logic [8:0] sl_data = 9'h0;
  logic       sl_latch_tail;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       out_err;
  logic [0:0] out_src;

  logic [1:0] wd_req = 2'b00;
  logic [1:0] wd_grant;
  logic [8:0] wd_addr;
  logic [8:0] wd_data = 9'h0;
  logic       wd_tail;
  logic [7:0] wd_odata;
  logic       wd_valid;
  logic       wd_ready = 1'b1;
  logic       wd_last;
  logic       wd_err;
  logic [0:0] wd_src;

  logic [8:0] ring    [RING];
  logic [8:0] wd_ring [RING];

  int    tests = 0;
  int    fails = 0;
  int    latch_cnt = 0;
  int    rdy_mode = 1;
  logic  force_rdy = 1'b1;
  int    m_ptr = 0;
  int    m_rr = 0;
  beat_t cap_q[$];

  mbus_ice_sl_drain #(.NUM_REQ(2), .ADDR_W(9), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .sl_arb_request(sl_arb_request),
    .sl_arb_grant(sl_arb_grant), .sl_addr(sl_addr), .sl_data(sl_data),
    .sl_latch_tail(sl_latch_tail), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_err(out_err),
    .out_src(out_src)
  );

  mbus_ice_sl_drain #(.NUM_REQ(2), .ADDR_W(9), .MAX_LEN(4)) dut_wd (
    .clk(clk), .reset(reset), .sl_arb_request(wd_req),
    .sl_arb_grant(wd_grant), .sl_addr(wd_addr), .sl_data(wd_data),
    .sl_latch_tail(wd_tail), .out_data(wd_odata), .out_valid(wd_valid),
    .out_ready(wd_ready), .out_last(wd_last), .out_err(wd_err),
    .out_src(wd_src)
  );

  always #5 clk = ~clk;

  // Registered-read ring RAMs
  always @(posedge clk) sl_data <= ring[sl_addr];
  always @(posedge clk) wd_data <= wd_ring[wd_addr];

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid && out_ready)
      cap_q.push_back({out_data, out_last, out_err, out_src, sl_addr});
    if (reset && sl_latch_tail) begin
      latch_cnt++;
      check("latch_grant_held", 32'(sl_arb_grant != 2'b00), 32'd1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_ptr = 0;
    m_rr  = 0;
  endtask

  // Runs one frame; the expected stream is walked straight from the ring model.
  task automatic do_frame(input string tag, input logic [1:0] req, input int exp_src,
                          input int mode, input int stall_at);
    beat_t      exp_q[$];
    int         win;
    int         eff;
    int         p;
    int         guard;
    logic [8:0] w;
    logic       lst;
    logic       er;
    logic [8:0] p9;
    win = -1;
    for (int k = 0; k < 2; k++)
      if (win < 0 && req[(m_rr + k) % 2]) win = (m_rr + k) % 2;
    eff = (exp_src >= 0) ? exp_src : win;
    p = m_ptr;
    for (int n = 1; n <= MAXL; n++) begin
      w   = ring[p];
      lst = w[8] || (n == MAXL);
      er  = !w[8] && (n == MAXL);
      p9  = p[8:0];
      exp_q.push_back({w[7:0], lst, er, 1'(win), p9});
      p = (p + 1) % RING;
      if (lst) break;
    end
    cap_q.delete();
    rdy_mode  = mode;
    force_rdy = (stall_at == 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    sl_arb_request = req;
    guard = 0;
    do begin @(negedge clk); guard++; end while (sl_arb_grant == 2'b00 && guard < 20);
    check({tag, " grant_wait"}, 32'(guard < 20), 32'd1);
    check({tag, " grant"}, 32'(sl_arb_grant), 32'(2'b01 << eff));
    check({tag, " src"}, 32'(out_src), 32'(eff));
    @(posedge clk); #1;
    sl_arb_request = 2'b00;
    if (stall_at >= 0) begin
      guard = 0;
      while (cap_q.size() < stall_at && guard < 1000) begin @(negedge clk); guard++; end
      force_rdy = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
      check({tag, " stall_wait"}, 32'(guard < 20), 32'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, " stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, " stall_data"}, 32'(out_data), 32'(exp_q[stall_at].data));
        check({tag, " stall_addr"}, 32'(sl_addr), 32'(exp_q[stall_at].addr));
      end
      force_rdy = 1'b1;
    end
    guard = 0;
    while (!sl_latch_tail && guard < 4000) begin @(negedge clk); guard++; end
    check({tag, " latch_wait"}, 32'(guard < 4000), 32'd1);
    @(negedge clk);
    check({tag, " tail_one_cycle"}, 32'(sl_latch_tail), 32'd0);
    check({tag, " grant_drop"}, 32'(sl_arb_grant), 32'd0);
    check({tag, " src_drop"}, 32'(out_src), 32'd0);
    check({tag, " end_addr"}, 32'(sl_addr), 32'(p));
    check({tag, " beats"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s beat%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    m_ptr = p;
    m_rr  = (win + 1) % 2;
  endtask

  arb_vec_t   vecs[9];
  beat_t      wd_q[$];
  logic [1:0] rq;
  int         guard;
  int         lc;
  logic       seen_tail;

  initial begin
    vecs[0] = '{2'b11, 0};
    vecs[1] = '{2'b11, 1};
    vecs[2] = '{2'b11, 0};
    vecs[3] = '{2'b10, 1};
    vecs[4] = '{2'b10, 1};
    vecs[5] = '{2'b01, 0};
    vecs[6] = '{2'b11, 1};
    vecs[7] = '{2'b01, 0};
    vecs[8] = '{2'b11, 1};
    for (int i = 0; i < RING; i++) begin
      ring[i]    = {1'($urandom_range(0, 3) == 0), 8'($urandom)};
      wd_ring[i] = {1'b0, 8'($urandom)};
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst grant", 32'(sl_arb_grant), 32'd0);
    check("rst addr", 32'(sl_addr), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst tail", 32'(sl_latch_tail), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    check("rst last_err_src", 32'({out_last, out_err, out_src}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    ring[0] = 9'h0AA; ring[1] = 9'h0BB; ring[2] = 9'h0CC; ring[3] = 9'h15A;
    do_frame("single", 2'b10, 1, 1, -1);
    check("single end_ptr", 32'(sl_addr), 32'd4);

    do_reset();
    do_frame("backpressure", 2'b10, 1, 0, 1);

    do_reset();
    foreach (vecs[i]) do_frame($sformatf("arb%0d", i), vecs[i].req, vecs[i].exp_src, 2, -1);

    for (int i = 0; i < 15; i++) begin
      rq = 2'($urandom_range(1, 3));
      do_frame($sformatf("rnd%0d", i), rq, -1, ($urandom_range(0, 1) == 0) ? 1 : 2, -1);
    end

    do_reset();
    for (int i = 0; i < 510; i++) ring[i] = {1'(i == 254 || i == 509), 8'($urandom)};
    do_frame("fill_a", 2'b01, 0, 1, -1);
    do_frame("fill_b", 2'b10, 1, 1, -1);
    check("wrap preset", 32'(sl_addr), 32'd510);
    ring[510] = 9'h011; ring[511] = 9'h022; ring[0] = 9'h1FF;
    do_frame("wrap", 2'b01, 0, 1, -1);
    check("wrap end_ptr", 32'(sl_addr), 32'd1);

    // Watchdog instance: ring has no markers, frame is cut after 4 words
    @(posedge clk); #1;
    wd_req = 2'b01;
    seen_tail = 1'b0;
    guard = 0;
    while (!seen_tail && guard < 100) begin
      @(negedge clk);
      guard++;
      if (wd_grant != 2'b00) wd_req = 2'b00;
      if (wd_valid && wd_ready) wd_q.push_back({wd_odata, wd_last, wd_err, wd_src, wd_addr});
      if (wd_tail) seen_tail = 1'b1;
    end
    check("wd tail_seen", 32'(seen_tail), 32'd1);
    check("wd beats", 32'(wd_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wd_q.size(); i++) begin
      check($sformatf("wd data%0d", i), 32'(wd_q[i].data), 32'(wd_ring[i][7:0]));
      check($sformatf("wd last%0d", i), 32'(wd_q[i].last), 32'(i == 3));
      check($sformatf("wd err%0d", i), 32'(wd_q[i].err), 32'(i == 3));
    end
    @(negedge clk);
    check("wd end_addr", 32'(wd_addr), 32'd4);
    check("wd grant_drop", 32'(wd_grant), 32'd0);

    // Asynchronous reset while a byte is pending in SEND
    do_reset();
    ring[0] = 9'h031; ring[1] = 9'h032; ring[2] = 9'h033; ring[3] = 9'h134;
    rdy_mode  = 0;
    force_rdy = 1'b0;
    @(posedge clk); #1;
    sl_arb_request = 2'b01;
    guard = 0;
    while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
    check("arst send_wait", 32'(guard < 20), 32'd1);
    lc = latch_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    sl_arb_request = 2'b00;
    #1;
    check("arst grant", 32'(sl_arb_grant), 32'd0);
    check("arst valid", 32'(out_valid), 32'd0);
    check("arst addr", 32'(sl_addr), 32'd0);
    check("arst tail", 32'(sl_latch_tail), 32'd0);
    repeat (3) @(posedge clk);
    check("arst no_latch", 32'(latch_cnt), 32'(lc));
    #1;
    reset = 1'b1;
    m_ptr = 0;
    m_rr  = 0;
    do_frame("replay", 2'b01, 0, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
